// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset main controller.
// Optional memory handshake is enabled with the MC_CTRL_MEM_WAIT_EN macro.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_RS     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    // One-hot instruction class; all-zero means undecodable.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } instr_t;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic [1:0] npc_sel;
        logic       ext_op;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       mem_we;
        logic       retire;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder producing a one-hot instruction class.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output instr_t     cls,
    output logic       illegal
);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls.addu = 1'b1;
                    FN_SUBU: cls.subu = 1'b1;
                    FN_JR:   cls.jr   = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: ;
        endcase
    end

    assign illegal = (cls == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing and datapath strobes.
// Define MC_CTRL_MEM_WAIT_EN to add the mem_ready handshake on FETCH and MEM.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pc_we,
    output logic       ir_we,
    output logic [1:0] npc_sel,
    output logic       ext_op,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       mem_we,
    output logic [2:0] state,
    output logic       retire,
    output logic       illegal
);

    state_t state_q, state_d;
    instr_t cls;
    logic   dec_illegal;
    logic   mem_rdy;
    ctrl_t  c;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    mc_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        c       = '0;
        case (state_q)
            S_FETCH: begin
                c.ir_we   = mem_rdy;
                c.pc_we   = mem_rdy;
                c.npc_sel = NPC_PC4;
                state_d   = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (cls.j || cls.jal) begin
                    c.pc_we   = 1'b1;
                    c.npc_sel = NPC_JUMP;
                    c.retire  = 1'b1;
                    if (cls.jal) begin
                        // PC already holds PC+4, which is the link value.
                        c.reg_we  = 1'b1;
                        c.reg_dst = DST_RA;
                        c.wd_sel  = WD_PC;
                    end
                end else if (cls.jr) begin
                    c.pc_we   = 1'b1;
                    c.npc_sel = NPC_RS;
                    c.retire  = 1'b1;
                end else if (dec_illegal) begin
                    c.illegal = 1'b1;
                    c.retire  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls.addu || cls.subu) begin
                    c.alu_op = cls.subu ? ALU_SUB : ALU_ADD;
                    state_d  = S_WB;
                end else if (cls.ori || cls.lui) begin
                    c.alu_src_b = 1'b1;
                    c.alu_op    = cls.lui ? ALU_LUI : ALU_OR;
                    state_d     = S_WB;
                end else if (cls.lw || cls.sw) begin
                    c.ext_op    = 1'b1;
                    c.alu_src_b = 1'b1;
                    c.alu_op    = ALU_ADD;
                    state_d     = S_MEM;
                end else if (cls.beq) begin
                    c.ext_op  = 1'b1;
                    c.alu_op  = ALU_SUB;
                    c.npc_sel = NPC_BRANCH;
                    c.pc_we   = zero;
                    c.retire  = 1'b1;
                end
            end
            S_MEM: begin
                if (cls.sw) begin
                    c.mem_we = 1'b1;
                    c.retire = mem_rdy;
                    state_d  = mem_rdy ? S_FETCH : S_MEM;
                end else if (cls.lw) begin
                    state_d = mem_rdy ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                c.reg_we  = 1'b1;
                c.retire  = 1'b1;
                c.reg_dst = (cls.addu || cls.subu) ? DST_RD : DST_RT;
                c.wd_sel  = cls.lw ? WD_DM : WD_ALU;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset is asynchronous, so strobes must drop the moment it rises.
        if (reset) c = '0;
    end

    assign state     = state_q;
    assign pc_we     = c.pc_we;
    assign ir_we     = c.ir_we;
    assign npc_sel   = c.npc_sel;
    assign ext_op    = c.ext_op;
    assign alu_src_b = c.alu_src_b;
    assign alu_op    = c.alu_op;
    assign reg_we    = c.reg_we;
    assign reg_dst   = c.reg_dst;
    assign wd_sel    = c.wd_sel;
    assign mem_we    = c.mem_we;
    assign retire    = c.retire;
    assign illegal   = c.illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; covers the mem_ready handshake when MC_CTRL_MEM_WAIT_EN is defined.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_we, ir_we, ext_op, alu_src_b, reg_we, mem_we, retire, illegal;
    logic [1:0] npc_sel, alu_op, reg_dst, wd_sel;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  exp_st [5];
    logic [15:0] exp_ov [5];

    mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
`ifdef MC_CTRL_MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .npc_sel   (npc_sel),
        .ext_op    (ext_op),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .mem_we    (mem_we),
        .state     (state),
        .retire    (retire),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    wire [15:0] outs = {pc_we, ir_we, npc_sel, ext_op, alu_src_b, alu_op,
                        reg_we, reg_dst, wd_sel, mem_we, retire, illegal};

    // Expected output word, field order matches `outs`.
    function automatic logic [15:0] o(input logic pw, input logic iw, input logic [1:0] npc,
                                      input logic ext, input logic asrc, input logic [1:0] aop,
                                      input logic rwe, input logic [1:0] rdst, input logic [1:0] wds,
                                      input logic mwe, input logic ret, input logic ill);
        return {pw, iw, npc, ext, asrc, aop, rwe, rdst, wds, mwe, ret, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered just after a negedge in FETCH; leaves just after the negedge of the next FETCH.
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int n);
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("%s_state%0d", tag, i), {29'd0, state}, {29'd0, exp_st[i]});
            check($sformatf("%s_outs%0d", tag, i), {16'd0, outs}, {16'd0, exp_ov[i]});
        end
        @(negedge clk);
    endtask

    logic [15:0] fe;
    logic [15:0] nil;

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        fe  = o(1,1,2'd0,0,0,2'd0,0,2'd0,2'd0,0,0,0);
        nil = 16'h0000;

        // Reset held three cycles: FETCH code with every strobe low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_state%0d", i), {29'd0, state}, 32'd0);
            check($sformatf("rst_outs%0d", i), {16'd0, outs}, 32'd0);
        end
        reset = 1'b0;

        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        exp_ov = '{fe, nil, o(0,0,2'd0,0,1,2'b10,0,2'd0,2'd0,0,0,0),
                   o(0,0,2'd0,0,0,2'd0,1,2'b00,2'b00,0,1,0), nil};
        run("ori", OP_ORI, 6'd0, 1'b0, 4);

        exp_ov[2] = o(0,0,2'd0,0,1,2'b11,0,2'd0,2'd0,0,0,0);
        run("lui", OP_LUI, 6'd0, 1'b0, 4);

        exp_ov = '{fe, nil, nil, o(0,0,2'd0,0,0,2'd0,1,2'b01,2'b00,0,1,0), nil};
        run("addu", OP_RTYPE, FN_ADDU, 1'b0, 4);
        exp_ov[2] = o(0,0,2'd0,0,0,2'b01,0,2'd0,2'd0,0,0,0);
        run("subu", OP_RTYPE, FN_SUBU, 1'b0, 4);

        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        exp_ov = '{fe, nil, o(0,0,2'd0,1,1,2'b00,0,2'd0,2'd0,0,0,0), nil,
                   o(0,0,2'd0,0,0,2'd0,1,2'b00,2'b01,0,1,0)};
        run("lw", OP_LW, 6'd0, 1'b0, 5);

        exp_ov[3] = o(0,0,2'd0,0,0,2'd0,0,2'd0,2'd0,1,1,0);
        run("sw", OP_SW, 6'd0, 1'b0, 4);

        exp_st = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
        exp_ov = '{fe, nil, o(1,0,2'b01,1,0,2'b01,0,2'd0,2'd0,0,1,0), nil, nil};
        run("beq_taken", OP_BEQ, 6'd0, 1'b1, 3);
        exp_ov[2] = o(0,0,2'b01,1,0,2'b01,0,2'd0,2'd0,0,1,0);
        run("beq_not", OP_BEQ, 6'd0, 1'b0, 3);

        exp_st = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
        exp_ov = '{fe, o(1,0,2'b10,0,0,2'd0,1,2'b10,2'b10,0,1,0), nil, nil, nil};
        run("jal", OP_JAL, 6'd0, 1'b0, 2);
        exp_ov[1] = o(1,0,2'b10,0,0,2'd0,0,2'd0,2'd0,0,1,0);
        run("j", OP_J, 6'd0, 1'b0, 2);
        exp_ov[1] = o(1,0,2'b11,0,0,2'd0,0,2'd0,2'd0,0,1,0);
        run("jr", OP_RTYPE, FN_JR, 1'b0, 2);
        exp_ov[1] = o(0,0,2'd0,0,0,2'd0,0,2'd0,2'd0,0,1,1);
        run("illegal_op", 6'b111111, 6'd0, 1'b0, 2);
        run("illegal_fn", OP_RTYPE, 6'b000000, 1'b0, 2);

        // Reset asserted mid-instruction (lw in EXEC) aborts with no strobes.
        opcode = OP_LW;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_state", {29'd0, state}, 32'd0);
        check("midrst_outs", {16'd0, outs}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        exp_ov = '{fe, nil, o(0,0,2'd0,1,1,2'b00,0,2'd0,2'd0,0,0,0),
                   o(0,0,2'd0,0,0,2'd0,0,2'd0,2'd0,1,1,0), nil};
        run("sw_after_rst", OP_SW, 6'd0, 1'b0, 4);

`ifdef MC_CTRL_MEM_WAIT_EN
        // FETCH stalls three cycles, then MEM of the sw stalls three cycles.
        opcode    = OP_SW;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wfetch_state%0d", i), {29'd0, state}, 32'd0);
            check($sformatf("wfetch_outs%0d", i), {16'd0, outs}, 32'd0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        check("wfetch_ready", {16'd0, outs}, {16'd0, fe});
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wmem_state%0d", i), {29'd0, state}, 32'd3);
            check($sformatf("wmem_outs%0d", i), {16'd0, outs},
                  {16'd0, o(0,0,2'd0,0,0,2'd0,0,2'd0,2'd0,1,0,0)});
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        check("wmem_ready", {16'd0, outs}, {16'd0, o(0,0,2'd0,0,0,2'd0,0,2'd0,2'd0,1,1,0)});
        @(negedge clk);
        check("wmem_next", {29'd0, state}, 32'd0);

        // Reset pulsed while an sw waits in MEM.
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("wrst_in_mem", {29'd0, state}, 32'd3);
        reset = 1'b1;
        #1;
        check("wrst_mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("wrst_state", {29'd0, state}, 32'd0);
        check("wrst_outs", {16'd0, outs}, {16'd0, fe});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS-subset datapath. It sequences one instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath select and write-enable, including `ext_op` for the 16-bit immediate extender (1 = sign, 0 = zero). It sits beside the IR and takes opcode/funct from the IR output. It is the only source of PC, IR, GRF and DM write strobes.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26]; valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU equality flag; sampled in EXEC.
- `mem_ready` in 1: memory access complete. Present only with `MC_CTRL_MEM_WAIT_EN`.
- `pc_we` out 1: PC write.
- `ir_we` out 1: IR write.
- `npc_sel` out 2: next-PC select. 00 = PC+4, 01 = branch, 10 = j-target, 11 = rs.
- `ext_op` out 1: 1 = sign-extend, 0 = zero-extend.
- `alu_src_b` out 1: ALU B operand. 0 = rt, 1 = extended immediate.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = or, 11 = lui (B<<16).
- `reg_we` out 1: GRF write.
- `reg_dst` out 2: destination register. 00 = rt, 01 = rd, 10 = $31.
- `wd_sel` out 2: GRF write data. 00 = ALU, 01 = DM, 10 = PC.
- `mem_we` out 1: DM write.
- `state` out 3: current state, for debug.
- `retire` out 1: high in the final cycle of each instruction.
- `illegal` out 1: undecodable instruction in DECODE.

## Operation
- **State encoding:** FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Codes 5–7 return to FETCH.
- **Instruction classes** (opcode/funct):
  - addu: 000000/100001
  - subu: 000000/100011
  - jr: 000000/001000
  - ori: 001101
  - lui: 001111
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - j: 000010
  - jal: 000011
- **FETCH:** `ir_we` = 1, `pc_we` = 1, `npc_sel` = 00. Next state DECODE.
- **DECODE:**
  - j: `pc_we` = 1, `npc_sel` = 10, `retire`; next FETCH.
  - jal: same as j, plus `reg_we` = 1, `reg_dst` = 10, `wd_sel` = 10 (PC already holds PC+4); next FETCH.
  - jr: `pc_we` = 1, `npc_sel` = 11, `retire`; next FETCH.
  - Illegal: `illegal` = 1, `retire`; next FETCH, with no other strobes (executes as a nop).
  - All others: next EXEC.
- **EXEC:**
  - addu/subu: `alu_src_b` = 0, `alu_op` = 00/01 → WB.
  - ori: `ext_op` = 0, `alu_src_b` = 1, `alu_op` = 10 → WB.
  - lui: `alu_src_b` = 1, `alu_op` = 11, `ext_op` = 0 → WB.
  - lw/sw: `ext_op` = 1, `alu_src_b` = 1, `alu_op` = 00 → MEM.
  - beq: `ext_op` = 1, `alu_op` = 01, `npc_sel` = 01, `pc_we` = `zero`, `retire` → FETCH.
- **MEM:**
  - sw: `mem_we` = 1, `retire` → FETCH.
  - lw: → WB.
- **WB:** `reg_we` = 1, `retire` → FETCH.
  - R-type: `reg_dst` = 01, `wd_sel` = 00.
  - ori/lui: `reg_dst` = 00, `wd_sel` = 00.
  - lw: `reg_dst` = 00, `wd_sel` = 01.
- **Output default:** any output not listed for a state is 0.

## Timing
- **State register:** the only state element. Outputs are combinational from `state`, `opcode`, `funct` and `zero`.
- **Reset:** while `reset` is high, `state` = FETCH and all strobes (`pc_we`, `ir_we`, `reg_we`, `mem_we`, `retire`, `illegal`) are forced to 0. The first FETCH is the cycle after deassertion.
- **Mid-instruction reset:** reset asserted in any state aborts the instruction immediately, with no partial write after the assertion edge.
- **Latency (cycles):**
  - j/jal/jr/illegal: 2
  - beq: 3
  - addu/subu/ori/lui/sw: 4
  - lw: 5
- **`retire`:** exactly one pulse per instruction.

## Configuration
- **`MC_CTRL_MEM_WAIT_EN` defined:**
  - `mem_ready` port exists.
  - FETCH holds while `mem_ready` = 0. `ir_we` and `pc_we` are asserted only in the cycle with `mem_ready` = 1.
  - MEM holds while `mem_ready` = 0.
    - sw: `mem_we` stays high every MEM cycle; `retire` only on the ready cycle.
    - lw: advances to WB on the ready cycle.
- **Undefined:** no `mem_ready` port; FETCH and MEM take one cycle each.

## Structure
- **Package `mc_pkg`:** state enum, opcode/funct constants, and `npc_sel`/`alu_op`/`reg_dst`/`wd_sel` code constants.
- **Sub-module `mc_decode`:** combinational opcode/funct → one-hot instruction class plus `illegal`.
- **`mc_ctrl`:** instantiates `mc_decode`; holds the FSM and output logic.

## Test plan
- Reset held 3 cycles, then released → `state` = 0 and all strobes 0 during reset; `ir_we` = `pc_we` = 1 in the first cycle after release.
- ori (opcode 001101) → states 0,1,2,4. In EXEC: `ext_op` = 0, `alu_op` = 10, `alu_src_b` = 1. In WB: `reg_we` = 1, `reg_dst` = 00. `retire` asserted in the 4th cycle.
- lw then sw → lw: 5 cycles, `ext_op` = 1 in EXEC, `wd_sel` = 01 in WB. sw: `mem_we` = 1 in MEM only, 4 cycles total.
- beq with `zero` = 1, then beq with `zero` = 0 → `npc_sel` = 01 in EXEC for both; `pc_we` = 1 for the first, 0 for the second; 3 cycles each.
- jal, then opcode 111111 → jal: DECODE has `pc_we` = 1, `npc_sel` = 10, `reg_we` = 1, `reg_dst` = 10, `wd_sel` = 10. Illegal opcode: `illegal` = 1, `retire` = 1, no other strobes.
- With `MC_CTRL_MEM_WAIT_EN`: `mem_ready` low for 3 cycles in FETCH and MEM of an sw → FETCH held 4 cycles with `ir_we` only on the last; `mem_we` high for 4 cycles; `reset` pulsed during MEM → FETCH next cycle with `mem_we` = 0.
